// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: PS/2 keymap decode, HPS joystick merge, coin stretch,
// pause toggle and DIP capture for an arcade core, all in the clk_sys domain.
module arcade_input_mapper #(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          JOY_W        = 10,
  parameter int          COIN_BIT     = 8,
  parameter int          PAUSE_BIT    = 9,
  parameter logic [15:0] COIN_CYCLES  = 16'd9600,
  parameter int          NUM_DIPS     = 8,
  parameter logic [7:0]  DIP_INDEX    = 8'd254,
  parameter logic [7:0]  KEYMAP_INDEX = 8'd253
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [10:0]                  ps2_key,
  input  logic                         ioctl_wr,
  input  logic [7:0]                   ioctl_index,
  input  logic [24:0]                  ioctl_addr,
  input  logic [7:0]                   ioctl_data,
  input  logic [NUM_PLAYERS*JOY_W-1:0] joystick,
  output logic [NUM_PLAYERS*JOY_W-1:0] controls,
  output logic [NUM_DIPS*8-1:0]        dip,
  output logic                         pause,
  output logic                         busy,
  output logic                         overflow
);

  localparam int TOTAL = NUM_PLAYERS * JOY_W;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  // Event bookkeeping: {pressed, ext, code}
  logic             r_old_tog;
  logic             r_primed;
  logic             w_event;
  logic [9:0]       w_ev_data;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [9:0]       r_cur, w_cur_next;
  logic             r_pend_valid, w_pend_valid_next;
  logic [9:0]       r_pend, w_pend_next;
  logic             r_overflow, w_overflow_next;
  logic             w_deq;

  logic [7:0]       r_km_code [TOTAL];
  logic             r_km_ext  [TOTAL];
  logic             r_key     [TOTAL];
  logic [TOTAL-1:0] w_key_vec;
  logic [TOTAL-1:0] w_raw;
  logic             w_km_wr;
  logic             w_dip_wr;

  logic [NUM_PLAYERS-1:0] w_pause_bits;
  logic                   w_pause_any;
  logic                   r_pause_prev;
  logic                   r_pause;

  logic [7:0] r_dip [NUM_DIPS];

  // The first edge after reset is not trusted: the toggle bit may already be set.
  assign w_event   = r_primed & (ps2_key[10] ^ r_old_tog);
  assign w_ev_data = ps2_key[9:0];
  assign w_km_wr   = ioctl_wr && (ioctl_index == KEYMAP_INDEX);
  assign w_dip_wr  = ioctl_wr && (ioctl_index == DIP_INDEX);

  // Track the PS/2 toggle bit and arm event detection after one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_old_tog <= 1'b0;
      r_primed  <= 1'b0;
    end else begin
      r_old_tog <= ps2_key[10];
      r_primed  <= 1'b1;
    end
  end

  // Scan FSM and one-deep pending slot: state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cur        <= '0;
      r_pend_valid <= 1'b0;
      r_pend       <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_cur        <= w_cur_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend       <= w_pend_next;
      r_overflow   <= w_overflow_next;
    end
  end

  // Scan FSM next state; pending slot is drained before a fresh event is taken
  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_cur_next        = r_cur;
    w_pend_valid_next = r_pend_valid;
    w_pend_next       = r_pend;
    w_overflow_next   = r_overflow;
    w_deq             = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pend_valid) begin
          w_cur_next   = r_pend;
          w_deq        = 1'b1;
          w_idx_next   = '0;
          w_state_next = S_SCAN;
        end else if (w_event) begin
          w_cur_next   = w_ev_data;
          w_idx_next   = '0;
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_idx == LAST_IDX) begin
          if (r_pend_valid) begin
            // Chain straight into the queued event without an idle cycle
            w_cur_next = r_pend;
            w_deq      = 1'b1;
            w_idx_next = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_idx_next = r_idx + IDX_W'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // An event not consumed directly goes to the pending slot, which may be
    // freed in this very cycle by a dequeue; otherwise it is lost.
    if (w_event && !(r_state == S_IDLE && !r_pend_valid)) begin
      if (!r_pend_valid || w_deq) begin
        w_pend_next       = w_ev_data;
        w_pend_valid_next = 1'b1;
      end else begin
        w_overflow_next = 1'b1;
      end
    end else if (w_deq) begin
      w_pend_valid_next = 1'b0;
    end
  end

  // Per-entry keymap storage and key state
  for (genvar gi = 0; gi < TOTAL; gi++) begin : g_entry
    logic w_hit;
    assign w_hit = (r_state == S_SCAN) && (r_idx == IDX_W'(gi)) &&
                   ({r_km_ext[gi], r_km_code[gi]} == r_cur[8:0]) &&
                   ({r_km_ext[gi], r_km_code[gi]} != 9'h000);
    assign w_key_vec[gi] = r_key[gi];

    // Keymap entry load from ioctl: even byte is the code, odd byte the ext flag
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_km_code[gi] <= 8'h00;
        r_km_ext[gi]  <= 1'b0;
      end else if (w_km_wr) begin
        if (ioctl_addr == 25'(2 * gi))     r_km_code[gi] <= ioctl_data;
        if (ioctl_addr == 25'(2 * gi + 1)) r_km_ext[gi]  <= ioctl_data[0];
      end
    end

    // Key state follows the pressed flag of the scanned event on a match
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_key[gi] <= 1'b0;
      else if (w_hit) r_key[gi] <= r_cur[9];
    end
  end

  assign w_raw = w_key_vec | joystick;

  // Per-player output register and coin stretcher
  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic             w_raw_coin;
    logic             r_coin_prev;
    logic [15:0]      r_coin_cnt;
    logic [JOY_W-1:0] w_ctrl_next;
    logic [JOY_W-1:0] r_ctrl;

    assign w_raw_coin       = w_raw[gi*JOY_W + COIN_BIT];
    assign w_pause_bits[gi] = w_raw[gi*JOY_W + PAUSE_BIT];

    // Coin counter reloads on every raw rising edge and runs down to zero
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_coin_prev <= 1'b0;
        r_coin_cnt  <= 16'd0;
      end else begin
        r_coin_prev <= w_raw_coin;
        if (w_raw_coin && !r_coin_prev) r_coin_cnt <= COIN_CYCLES;
        else if (r_coin_cnt != 16'd0)   r_coin_cnt <= r_coin_cnt - 16'd1;
      end
    end

    // Raw controls with the coin bit held high while the counter runs
    always_comb begin
      w_ctrl_next           = w_raw[gi*JOY_W +: JOY_W];
      w_ctrl_next[COIN_BIT] = w_raw_coin | (r_coin_cnt != 16'd0);
    end

    // Register the merged player vector
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_ctrl <= '0;
      else          r_ctrl <= w_ctrl_next;
    end

    assign controls[gi*JOY_W +: JOY_W] = r_ctrl;
  end

  assign w_pause_any = |w_pause_bits;

  // Pause flips on each rising edge of any player's pause request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pause_prev <= 1'b0;
      r_pause      <= 1'b0;
    end else begin
      r_pause_prev <= w_pause_any;
      if (w_pause_any && !r_pause_prev) r_pause <= ~r_pause;
    end
  end

  // DIP byte capture; addresses beyond the last byte match no entry
  for (genvar gi = 0; gi < NUM_DIPS; gi++) begin : g_dip
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                 r_dip[gi] <= 8'h00;
      else if (w_dip_wr && ioctl_addr == 25'(gi))   r_dip[gi] <= ioctl_data;
    end
    assign dip[gi*8 +: 8] = r_dip[gi];
  end

  assign pause    = r_pause;
  assign busy     = (r_state == S_SCAN);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Testbench for arcade_input_mapper: scoreboard of expected control/pause/
// overflow states pushed per PS/2 event and compared after the scan settles.
module tb_arcade_input_mapper;

  localparam int TOTAL = 20;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [19:0] joystick;
  logic [19:0] controls;
  logic [63:0] dip;
  logic        pause, busy, overflow;

  always #5 clk = ~clk;

  arcade_input_mapper #(
    .NUM_PLAYERS(2), .JOY_W(10), .COIN_BIT(8), .PAUSE_BIT(9),
    .COIN_CYCLES(16'd16), .NUM_DIPS(8), .DIP_INDEX(8'd254), .KEYMAP_INDEX(8'd253)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .joystick(joystick), .controls(controls), .dip(dip), .pause(pause),
    .busy(busy), .overflow(overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model
  logic [7:0] m_code [TOTAL];
  logic       m_ext  [TOTAL];
  logic       m_key  [TOTAL];
  logic       m_pause, m_ovf;

  typedef struct {
    string       tag;
    logic [19:0] ctl;
    logic        pse;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  function automatic logic [19:0] model_ctl();
    logic [19:0] r;
    for (int i = 0; i < TOTAL; i++) r[i] = m_key[i] | joystick[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TOTAL; i++) begin
      m_code[i] = 8'h00; m_ext[i] = 1'b0; m_key[i] = 1'b0;
    end
    m_pause = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_event(input logic p, input logic e, input logic [7:0] c);
    logic old_p, new_p;
    old_p = m_key[9] | m_key[19] | joystick[9] | joystick[19];
    for (int i = 0; i < TOTAL; i++)
      if ({m_ext[i], m_code[i]} != 9'h000 && {m_ext[i], m_code[i]} == {e, c}) m_key[i] = p;
    new_p = m_key[9] | m_key[19] | joystick[9] | joystick[19];
    if (!old_p && new_p) m_pause = ~m_pause;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.ctl = model_ctl(); e.pse = m_pause; e.ovf = m_ovf;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      $display("txn %s: controls=%h pause=%b overflow=%b (want %h %b %b)",
               e.tag, controls, pause, overflow, e.ctl, e.pse, e.ovf);
      check_val({e.tag, ".ctl"}, 64'(controls), 64'(e.ctl));
      check_val({e.tag, ".pause"}, 64'(pause), 64'(e.pse));
      check_val({e.tag, ".ovf"}, 64'(overflow), 64'(e.ovf));
    end
  endtask

  task automatic drive_event(input logic p, input logic e, input logic [7:0] c);
    ps2_key = {~ps2_key[10], p, e, c};
  endtask

  // Counts busy cycles from the next sample point, then lets outputs settle
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check_val("busy_timeout", 64'(n), 64'd0);
    @(negedge clk);
  endtask

  task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr = 1'b1; ioctl_index = idx; ioctl_addr = addr; ioctl_data = data;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic km_write(input int i, input logic [7:0] code, input logic ext);
    ioctl_write(8'd253, 25'(2 * i), code);
    ioctl_write(8'd253, 25'(2 * i + 1), {7'b0, ext});
    m_code[i] = code;
    m_ext[i]  = ext;
  endtask

  task automatic event_txn(input string tag, input logic p, input logic e, input logic [7:0] c);
    int n;
    drive_event(p, e, c);
    model_event(p, e, c);
    push_exp(tag);
    wait_idle(n);
    check_val({tag, ".busy_len"}, 64'(n), 64'd20);
    drain();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi;
    logic [7:0] dvals [9];
    logic       busy_seen;
    dvals = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h12, 8'h34, 8'hFF};

    reset_n = 1'b0; ps2_key = '0; ioctl_wr = 1'b0; ioctl_index = '0;
    ioctl_addr = '0; ioctl_data = '0; joystick = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst.controls", 64'(controls), 64'd0);
    check_val("rst.dip", dip, 64'd0);
    check_val("rst.pause", 64'(pause), 64'd0);
    check_val("rst.busy", 64'(busy), 64'd0);
    check_val("rst.overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    km_write(0, 8'h74, 1'b1);
    km_write(4, 8'h14, 1'b0);
    km_write(14, 8'h14, 1'b0);
    km_write(19, 8'h77, 1'b0);

    // First press with cycle-exact latency on entry 0
    drive_event(1'b1, 1'b1, 8'h74);
    model_event(1'b1, 1'b1, 8'h74);
    push_exp("press_74e");
    @(negedge clk);
    check_val("lat.busy_rise", 64'(busy), 64'd1);
    check_val("lat.e0", 64'(controls[0]), 64'd0);
    @(negedge clk);
    check_val("lat.e1", 64'(controls[0]), 64'd0);
    @(negedge clk);
    check_val("lat.e2", 64'(controls[0]), 64'd1);
    n = 2;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_val("press_74e.busy_len", 64'(n), 64'd20);
    @(negedge clk);
    drain();

    event_txn("release_74e", 1'b0, 1'b1, 8'h74);
    event_txn("press_14", 1'b1, 1'b0, 8'h14);
    event_txn("press_14e", 1'b1, 1'b1, 8'h14);
    event_txn("press_00", 1'b1, 1'b0, 8'h00);
    event_txn("release_14", 1'b0, 1'b0, 8'h14);

    // Coin stretch: single pulse, then pulse re-armed 10 cycles in
    joystick[8] = 1'b1;
    hi = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (controls[8]) hi++;
      joystick[8] = 1'b0;
    end
    check_val("coin.single", 64'(hi), 64'd17);
    joystick[8] = 1'b1;
    hi = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (controls[8]) hi++;
      joystick[8] = (t == 9);
    end
    check_val("coin.repulse", 64'(hi), 64'd27);

    // Joystick pass-through is registered
    joystick[11] = 1'b1;
    push_exp("joy_p2_left");
    #1;
    check_val("joy.reg", 64'(controls[11]), 64'd0);
    @(negedge clk);
    drain();
    joystick[11] = 1'b0;
    push_exp("joy_p2_idle");
    @(negedge clk);
    drain();

    // Player 2 pause key toggles pause on presses only
    event_txn("pause_press1", 1'b1, 1'b0, 8'h77);
    event_txn("pause_rel1", 1'b0, 1'b0, 8'h77);
    event_txn("pause_press2", 1'b1, 1'b0, 8'h77);
    event_txn("pause_rel2", 1'b0, 1'b0, 8'h77);

    // Three events back to back: scan, pending, dropped
    drive_event(1'b1, 1'b1, 8'h74);
    model_event(1'b1, 1'b1, 8'h74);
    @(negedge clk);
    drive_event(1'b1, 1'b0, 8'h14);
    model_event(1'b1, 1'b0, 8'h14);
    @(negedge clk);
    drive_event(1'b1, 1'b0, 8'h77);
    m_ovf = 1'b1;
    push_exp("burst");
    wait_idle(n);
    check_val("burst.busy_len", 64'(n + 2), 64'd40);
    drain();
    event_txn("after_ovf", 1'b0, 1'b1, 8'h74);

    // DIP download, with out-of-range and wrong-index writes ignored
    for (int a = 0; a < 9; a++) ioctl_write(8'd254, 25'(a), dvals[a]);
    ioctl_write(8'd252, 25'd0, 8'h00);
    @(negedge clk);
    check_val("dip.byte0", 64'(dip[7:0]), 64'hA5);
    check_val("dip.byte1", 64'(dip[15:8]), 64'h3C);
    check_val("dip.all", dip, 64'h3412F00FC35A3CA5);

    // Reset in the middle of a scan
    drive_event(1'b1, 1'b1, 8'h74);
    repeat (5) @(negedge clk);
    check_val("pre_reset.busy", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst.controls", 64'(controls), 64'd0);
    check_val("arst.dip", dip, 64'd0);
    check_val("arst.pause", 64'(pause), 64'd0);
    check_val("arst.busy", 64'(busy), 64'd0);
    check_val("arst.overflow", 64'(overflow), 64'd0);
    ps2_key[10] = 1'b1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    busy_seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check_val("post_reset.no_event", 64'(busy_seen), 64'd0);
    event_txn("post_reset_unmapped", 1'b1, 1'b1, 8'h74);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
